// File: rtl/int_request_arbiter.sv
// rtl/int_request_arbiter.sv - edge-detecting fixed-priority interrupt request arbiter
// Latches rising edges as pending, serves the lowest enabled index, waits for ack.
module int_request_arbiter #(
  parameter int N_SRC       = 8,
  parameter int VEC_W       = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_enable,
  input  logic             int_ack,
  input  logic             int_clear_all,
  output logic             interruptsource,
  output logic [VEC_W-1:0] int_vector,
  output logic             int_busy,
  output logic [N_SRC-1:0] int_pending
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

  state_t           state;
  logic [N_SRC-1:0] irq_prev;
  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] ack_clr;
  logic [VEC_W-1:0] winner;
  logic [15:0]      cnt;

  always_comb begin
    edges   = irq_in & ~irq_prev;
    cand    = int_pending & irq_enable;
    winner  = '0;
    ack_clr = '0;
    // Scanning downwards leaves the lowest set index as the winner.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = VEC_W'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = (state == WAIT_ACK) && int_ack && (int_vector == VEC_W'(i));
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      irq_prev        <= '1;
      int_pending     <= '0;
      int_vector      <= '0;
      int_busy        <= 1'b0;
      interruptsource <= 1'b0;
      cnt             <= '0;
    end else begin
      irq_prev        <= irq_in;
      interruptsource <= 1'b0;
      if (int_clear_all) begin
        state       <= IDLE;
        int_pending <= '0;
        int_vector  <= '0;
        int_busy    <= 1'b0;
        cnt         <= '0;
      end else begin
        // A new edge on the acked source wins over the clear.
        int_pending <= (int_pending & ~ack_clr) | edges;
        case (state)
          IDLE: begin
            if (|cand) begin
              int_vector      <= winner;
              state           <= REQ;
              interruptsource <= 1'b1;
              int_busy        <= 1'b1;
            end
          end
          REQ: begin
            cnt   <= 16'(ACK_TIMEOUT);
            state <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (int_ack) begin
              state    <= IDLE;
              int_busy <= 1'b0;
            end else if (cnt <= 16'd1) begin
              cnt             <= '0;
              state           <= REQ;
              interruptsource <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
